ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. The existing keyboard path only receives; this block adds the outbound direction.
- Lets the VGA/keyboard subsystem send command bytes to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- Drives the open-collector PS2_KBCLK/PS2_KBDAT lines through pull-low enables; the top level owns the tristate buffers.
- Releases both lines when idle so the existing receiver works unchanged.

Parameters:
- CLK_FREQ_HZ, 50000000: system clock frequency; informational only.
- INHIBIT_CYCLES, 5000: cycles ps2 clock is held low before request-to-send (100 us at 50 MHz).
- START_TIMEOUT, 750000: max cycles to wait for the first device clock falling edge after RTS (15 ms).
- BIT_TIMEOUT, 100000: max cycles between consecutive device clock falling edges (2 ms).

Ports:
- clk  in  1  system clock, 50 MHz (CLOCK_50)
- reset  in  1  asynchronous, active-low reset
- tx_data  in  8  command byte; sampled on an accepted tx_start
- tx_start  in  1  single-cycle request; ignored while tx_busy=1
- tx_busy  out  1  high from the cycle after acceptance until done/error is pulsed
- tx_done  out  1  one-cycle pulse: byte sent and ACK received
- tx_error  out  1  one-cycle pulse: timeout or missing ACK
- ps2_clk_in  in  1  raw PS2 clock line level
- ps2_dat_in  in  1  raw PS2 data line level
- ps2_clk_low  out  1  1 = pull PS2 clock line low
- ps2_dat_low  out  1  1 = pull PS2 data line low

Behaviour:
- Reset (asserted, reset=0):
  - state=IDLE
  - tx_busy=0, tx_done=0, tx_error=0
  - ps2_clk_low=0, ps2_dat_low=0
  - all counters cleared
- Reset mid-frame: lines are released immediately (asynchronously) and no done/error pulse is produced.
- Input sync: ps2_clk_in and ps2_dat_in each pass through a 2-flop synchronizer. fall = sync_clk_prev=1 and sync_clk=0.
- State machine:
  - IDLE: on tx_start, latch tx_data and compute odd parity = ~^tx_data. Go to INHIBIT next cycle with tx_busy=1.
  - INHIBIT: ps2_clk_low=1 for exactly INHIBIT_CYCLES cycles. In the final cycle also set ps2_dat_low=1. Then go to RTS.
  - RTS: ps2_clk_low=0 and ps2_dat_low=1 (start bit 0). Wait for fall. Timeout after START_TIMEOUT cycles -> ERR.
  - SHIFT: falls 1-8 drive data bits 0-7 (LSB first), with ps2_dat_low = ~bit. Fall 9 drives parity. Fall 10 releases data (stop bit = 1).
  - ACK: on fall 11, sample sync_dat. Value 0 -> WAIT_IDLE; value 1 -> ERR.
  - WAIT_IDLE: wait until sync_clk=1 and sync_dat=1, then go to DONE.
  - DONE: tx_done=1 for one cycle, tx_busy=0, then IDLE.
  - ERR: release both lines, tx_error=1 for one cycle, tx_busy=0, then IDLE.
- Timeouts: the bit-timeout counter resets on every fall. Exceeding BIT_TIMEOUT in SHIFT, ACK or WAIT_IDLE -> ERR.
- Data line updates occur on the cycle after a detected fall, i.e. while the device clock is low.
- The data-line drive is registered with no combinational path from inputs. A bit count of 4 bits is sufficient.
- tx_start while busy is dropped; no queueing.
- A tx_start in the same cycle that tx_done or tx_error pulses is dropped. It is accepted from the following cycle (IDLE) onward.

Optional Feature:
- Macro: PS2_TX_GLITCH_FILTER_EN
- Defined:
  - sync_clk only changes after 8 consecutive identical synchronized samples.
  - fall detection latency grows by 8 cycles.
  - clock pulses shorter than 8 cycles are ignored.
- Undefined:
  - 2-flop synchronizer only; fall latency is 3 cycles from the raw edge.

Test Plan:
- Send 0xED with a device model clocking at a 60 us period and ACKing:
  - ps2_clk_low is high for exactly 5000 cycles.
  - Data bits sampled at falls 1-8 are 1,0,1,1,0,1,1,1; parity=1; stop=1.
  - tx_done pulses once and tx_busy falls in the same cycle.
- Send 0x00: parity bit = 1. Send 0xFF: parity bit = 1. Send 0x01: parity bit = 0.
- Device never clocks after RTS: tx_error pulses START_TIMEOUT cycles after RTS entry and both line drives drop to 0.
- Device holds data high on fall 11 (NACK): tx_error pulses, tx_done stays 0, and the next tx_start is accepted normally.
- tx_start re-pulsed during a frame with a different byte: it is ignored and the original byte completes.
- reset asserted at fall 5: ps2_clk_low=0, ps2_dat_low=0 and tx_busy=0 immediately. After release, a new transmit of 0xF4 completes correctly.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter.
// Sends one command byte to the device: inhibit, request-to-send, 8 data bits
// LSB first, odd parity, stop, then waits for the device ACK and bus idle.
// Outputs are pull-low enables; the top level owns the open-collector buffers.
// Optional build macro PS2_TX_GLITCH_FILTER_EN: the synchronized clock only
// changes after 8 consecutive identical samples, rejecting short glitches.
module ps2_host_tx #(
    parameter int CLK_FREQ_HZ    = 50000000,
    parameter int INHIBIT_CYCLES = 5000,
    parameter int START_TIMEOUT  = 750000,
    parameter int BIT_TIMEOUT    = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_low,
    output logic       ps2_dat_low
);

    localparam int MAX_AB = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
    localparam int MAXC   = (MAX_AB > BIT_TIMEOUT) ? MAX_AB : BIT_TIMEOUT;
    localparam int CNT_W  = $clog2(MAXC + 1);

    localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_TIMEOUT - 1);

    // Reject nonsensical parameterisations at elaboration time.
    if (CLK_FREQ_HZ < 1 || INHIBIT_CYCLES < 1 || START_TIMEOUT < 1 || BIT_TIMEOUT < 1) begin : g_param_check
        $error("ps2_host_tx: all clock/timing parameters must be positive");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_RTS, S_SHIFT, S_ACK, S_WAIT_IDLE, S_DONE, S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [8:0]       sh_q, sh_d;          // {parity, data}; shifts in 1s (stop/release)
    logic             dat_low_q, dat_low_d;
    logic             clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q, clk_prev_q;
    logic             sync_clk, sync_dat, fall;

    // Two-flop synchronizers; idle-high reset so no false fall follows reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk_in;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_dat_in;
            dat_s2_q <= dat_s1_q;
        end
    end

`ifdef PS2_TX_GLITCH_FILTER_EN
    logic [2:0] flt_cnt_q, flt_cnt_d;
    logic       flt_clk_q, flt_clk_d;

    // Flip the filtered clock only after 8 consecutive differing samples.
    always_comb begin
        flt_clk_d = flt_clk_q;
        flt_cnt_d = 3'd0;
        if (clk_s2_q != flt_clk_q) begin
            if (flt_cnt_q == 3'd7) begin
                flt_clk_d = clk_s2_q;
            end else begin
                flt_cnt_d = flt_cnt_q + 3'd1;
            end
        end
    end

    // Glitch filter state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flt_clk_q <= 1'b1;
            flt_cnt_q <= 3'd0;
        end else begin
            flt_clk_q <= flt_clk_d;
            flt_cnt_q <= flt_cnt_d;
        end
    end

    assign sync_clk = flt_clk_q;
`else
    assign sync_clk = clk_s2_q;
`endif

    assign sync_dat = dat_s2_q;
    assign fall     = clk_prev_q & ~sync_clk;
    assign ps2_dat_low = dat_low_q;

    // FSM state, counters, shift register and registered data-line drive.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= 4'd0;
            sh_q       <= 9'h1FF;
            dat_low_q  <= 1'b0;
            clk_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
            dat_low_q  <= dat_low_d;
            clk_prev_q <= sync_clk;
        end
    end

    // Next-state, counter and output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        sh_d        = sh_q;
        dat_low_d   = dat_low_q;
        tx_busy     = 1'b1;
        tx_done     = 1'b0;
        tx_error    = 1'b0;
        ps2_clk_low = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_busy = 1'b0;
                cnt_d   = '0;
                bit_d   = 4'd0;
                if (tx_start) begin
                    sh_d    = {~^tx_data, tx_data};
                    state_d = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                ps2_clk_low = 1'b1;
                if (cnt_q == INH_LAST) begin
                    cnt_d   = '0;
                    state_d = S_RTS;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RTS: begin
                if (fall) begin
                    dat_low_d = ~sh_q[0];
                    sh_d      = {1'b1, sh_q[8:1]};
                    bit_d     = 4'd1;
                    cnt_d     = '0;
                    state_d   = S_SHIFT;
                end else if (cnt_q == START_LAST) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SHIFT: begin
                if (fall) begin
                    dat_low_d = ~sh_q[0];
                    sh_d      = {1'b1, sh_q[8:1]};
                    bit_d     = bit_q + 4'd1;
                    cnt_d     = '0;
                    if (bit_q == 4'd9) begin
                        state_d = S_ACK;    // fall 10 just released the line
                    end
                end else if (cnt_q == BIT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ACK: begin
                if (fall) begin
                    cnt_d   = '0;
                    bit_d   = bit_q + 4'd1;
                    state_d = sync_dat ? S_ERR : S_WAIT_IDLE;
                end else if (cnt_q == BIT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (sync_clk && sync_dat) begin
                    state_d = S_DONE;
                end else if (fall) begin
                    cnt_d = '0;
                end else if (cnt_q == BIT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                tx_busy = 1'b0;
                tx_done = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                tx_busy  = 1'b0;
                tx_error = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Data drive follows the state being entered: start bit pulled low in
        // the last inhibit cycle and throughout RTS, released everywhere else.
        if (state_d == S_INHIBIT) begin
            dat_low_d = (cnt_d == INH_LAST);
        end else if (state_d == S_RTS) begin
            dat_low_d = 1'b1;
        end else if (state_d != S_SHIFT) begin
            dat_low_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device model.
module tb_ps2_host_tx;

    localparam int INH = 100;
    localparam int STO = 2000;
    localparam int BTO = 300;
    localparam int H   = 20;      // device clock half period in system cycles

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_busy, tx_done, tx_error;
    logic       ps2_clk_low, ps2_dat_low;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       clk_line, dat_line;

    assign clk_line = ~ps2_clk_low & ~dev_clk_low;
    assign dat_line = ~ps2_dat_low & ~dev_dat_low;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .CLK_FREQ_HZ   (50000000),
        .INHIBIT_CYCLES(INH),
        .START_TIMEOUT (STO),
        .BIT_TIMEOUT   (BTO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_error   (tx_error),
        .ps2_clk_in (clk_line),
        .ps2_dat_in (dat_line),
        .ps2_clk_low(ps2_clk_low),
        .ps2_dat_low(ps2_dat_low)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   inh_cyc = 0;
    int   done_pulses = 0;
    int   err_pulses = 0;
    int   done_busy_ok = 0;
    logic busy_prev = 1'b0;

    // Pulse and inhibit-length monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (ps2_clk_low) inh_cyc <= inh_cyc + 1;
        if (tx_done) begin
            done_pulses <= done_pulses + 1;
            if (!tx_busy && busy_prev) done_busy_ok <= done_busy_ok + 1;
        end
        if (tx_error) err_pulses <= err_pulses + 1;
        busy_prev <= tx_busy;
    end

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        chk("busy_after_accept", 32'(d), 32'(tx_busy), 32'd1);
    endtask

    task automatic wait_not_busy(input int tag);
        int n;
        n = 0;
        while (tx_busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("busy_release_timeout", tag, 32'(tx_busy), 32'd0);
    endtask

    // Device: wait for RTS, clock out 11 falls, sample data before each rise,
    // ACK fall 11 when asked. rst_fall>0 returns with the clock held low.
    task automatic dev_frame(input bit ack, input int rst_fall, output logic [10:0] bits, output bit ok);
        int n;
        bits = '0;
        ok   = 1'b0;
        n    = 0;
        while (!(clk_line && !dat_line)) begin
            @(negedge clk);
            n++;
            if (n > 4 * INH) return;
        end
        ok = 1'b1;
        repeat (H) @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
            dev_clk_low = 1'b1;
            if (k == rst_fall) begin
                repeat (6) @(negedge clk);
                return;
            end
            repeat (H) @(negedge clk);
            bits[k-1]   = dat_line;
            dev_clk_low = 1'b0;
            if (k == 10 && ack) begin
                repeat (H / 2) @(negedge clk);
                dev_dat_low = 1'b1;
                repeat (H - H / 2) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
        end
        dev_dat_low = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        bit         ack;
        logic [7:0] exp_bits;   // bit k = line level sampled after fall k+1
        logic       exp_par;
        int         exp_done;
        int         exp_err;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [10:0] bits;
        bit          ok;
        int          i0, d0, e0, b0, n;

        vecs[0] = '{8'hED, 1'b1, 8'b1110_1101, 1'b1, 1, 0};
        vecs[1] = '{8'h00, 1'b1, 8'b0000_0000, 1'b1, 1, 0};
        vecs[2] = '{8'h5A, 1'b0, 8'b0101_1010, 1'b1, 0, 1};
        vecs[3] = '{8'hFF, 1'b1, 8'b1111_1111, 1'b1, 1, 0};
        vecs[4] = '{8'h01, 1'b1, 8'b0000_0001, 1'b0, 1, 0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 0, 32'(tx_busy), 32'd0);
        chk("rst_done", 0, 32'(tx_done), 32'd0);
        chk("rst_error", 0, 32'(tx_error), 32'd0);
        chk("rst_clk_low", 0, 32'(ps2_clk_low), 32'd0);
        chk("rst_dat_low", 0, 32'(ps2_dat_low), 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Table-driven frames
        for (int i = 0; i < 5; i++) begin
            i0 = inh_cyc; d0 = done_pulses; e0 = err_pulses; b0 = done_busy_ok;
            send(vecs[i].data);
            dev_frame(vecs[i].ack, 0, bits, ok);
            chk("rts_seen", i, 32'(ok), 32'd1);
            wait_not_busy(i);
            repeat (4) @(negedge clk);
            chk("inhibit_cycles", i, 32'(inh_cyc - i0), 32'(INH));
            chk("data_bits", i, 32'(bits[7:0]), 32'(vecs[i].exp_bits));
            chk("parity_bit", i, 32'(bits[8]), 32'(vecs[i].exp_par));
            chk("stop_bit", i, 32'(bits[9]), 32'd1);
            chk("done_pulses", i, 32'(done_pulses - d0), 32'(vecs[i].exp_done));
            chk("error_pulses", i, 32'(err_pulses - e0), 32'(vecs[i].exp_err));
            chk("busy_drop_with_done", i, 32'(done_busy_ok - b0), 32'(vecs[i].exp_done));
        end

        // tx_start re-pulsed mid-frame with another byte is ignored
        d0 = done_pulses; e0 = err_pulses;
        send(8'hA5);
        fork
            dev_frame(1'b1, 0, bits, ok);
            begin
                repeat (50) @(negedge clk);
                tx_data = 8'h33; tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
                repeat (250) @(negedge clk);
                tx_data = 8'h33; tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
            end
        join
        wait_not_busy(100);
        repeat (150) @(negedge clk);
        chk("repulse_data", 0, 32'(bits[7:0]), 32'hA5);
        chk("repulse_parity", 0, 32'(bits[8]), 32'd1);
        chk("repulse_done", 0, 32'(done_pulses - d0), 32'd1);
        chk("repulse_error", 0, 32'(err_pulses - e0), 32'd0);
        chk("repulse_no_second_frame", 0, 32'(tx_busy), 32'd0);

        // Device never clocks: start timeout counted from RTS entry
        send(8'hC3);
        n = 0;
        while (!(!ps2_clk_low && ps2_dat_low) && n < 4 * INH) begin
            @(negedge clk);
            n++;
        end
        chk("rts_reached", 0, 32'(!ps2_clk_low && ps2_dat_low), 32'd1);
        n = 0;
        while (!tx_error && n < STO + 50) begin
            @(negedge clk);
            n++;
        end
        chk("start_timeout_cycles", 0, 32'(n), 32'(STO));
        chk("timeout_clk_low", 0, 32'(ps2_clk_low), 32'd0);
        chk("timeout_dat_low", 0, 32'(ps2_dat_low), 32'd0);
        chk("timeout_busy", 0, 32'(tx_busy), 32'd0);
        repeat (5) @(negedge clk);

        // Asynchronous reset at fall 5 of a 0x00 frame
        d0 = done_pulses; e0 = err_pulses;
        send(8'h00);
        dev_frame(1'b1, 5, bits, ok);
        chk("pre_reset_dat_low", 0, 32'(ps2_dat_low), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_clk_low", 0, 32'(ps2_clk_low), 32'd0);
        chk("async_rst_dat_low", 0, 32'(ps2_dat_low), 32'd0);
        chk("async_rst_busy", 0, 32'(tx_busy), 32'd0);
        dev_clk_low = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_no_done", 0, 32'(done_pulses - d0), 32'd0);
        chk("rst_no_error", 0, 32'(err_pulses - e0), 32'd0);

        // Recovery frame 0xF4
        d0 = done_pulses; e0 = err_pulses;
        send(8'hF4);
        dev_frame(1'b1, 0, bits, ok);
        wait_not_busy(200);
        repeat (4) @(negedge clk);
        chk("f4_data", 0, 32'(bits[7:0]), 32'hF4);
        chk("f4_parity", 0, 32'(bits[8]), 32'd0);
        chk("f4_stop", 0, 32'(bits[9]), 32'd1);
        chk("f4_done", 0, 32'(done_pulses - d0), 32'd1);
        chk("f4_error", 0, 32'(err_pulses - e0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
